// File: rtl/writeback_queue_if.sv
// ---------------------------------------------------------------------------
// writeback_queue_if : ALU / load-path writeback request handshakes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface writeback_queue_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_reg;
   logic [DATA_W-1:0] mem_data;
   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_reg;
   logic [DATA_W-1:0] alu_data;

   modport master (
      output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
      input  mem_ready, alu_ready
   );

   modport slave (
      input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
      output mem_ready, alu_ready
   );
endinterface

`default_nettype wire

// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue : in-order writeback FIFO feeding the register file port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  wire logic                     clk,
   input  wire logic                     rst_n,
   writeback_queue_if.slave              wb,
   input  wire logic                     hold,
   output logic                          regWrite,
   output logic [ADDR_W-1:0]             writeReg,
   output logic [DATA_W-1:0]             writeData,
   output logic [31:0]                   pending,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          full,
   output logic                          empty
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int COUNT_W = PTR_W + 1;
   localparam logic [COUNT_W-1:0] C_DEPTH = COUNT_W'(DEPTH);

   logic [ADDR_W-1:0]  r_reg_q  [DEPTH];
   logic [DATA_W-1:0]  r_data_q [DEPTH];
   logic [DEPTH-1:0]   r_vld;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [COUNT_W-1:0] r_count;
   logic               r_reg_write;
   logic [ADDR_W-1:0]  r_write_reg;
   logic [DATA_W-1:0]  r_write_data;

   logic               w_full;
   logic               w_mem_fire;
   logic               w_alu_fire;
   logic [ADDR_W-1:0]  w_acc_reg;
   logic [DATA_W-1:0]  w_acc_data;
   logic               w_push;
   logic               w_pop;
   logic [31:0]        w_pending;

   // Readiness depends only on registered occupancy, never on this cycle's pop.
   assign w_full       = (r_count == C_DEPTH);
   assign wb.mem_ready = rst_n & ~w_full;
   assign wb.alu_ready = rst_n & ~w_full & ~wb.mem_valid;

   assign w_mem_fire = wb.mem_valid & wb.mem_ready;
   assign w_alu_fire = wb.alu_valid & wb.alu_ready;
   assign w_acc_reg  = w_mem_fire ? wb.mem_reg  : wb.alu_reg;
   assign w_acc_data = w_mem_fire ? wb.mem_data : wb.alu_data;

   // Writes to $0 complete the handshake but are silently discarded.
   assign w_push = (w_mem_fire | w_alu_fire) & (w_acc_reg != '0);
   assign w_pop  = (r_count != '0) & ~hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_vld        <= '0;
         r_reg_write  <= 1'b0;
         r_write_reg  <= '0;
         r_write_data <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            r_vld[r_wr_ptr] <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
            r_vld[r_rd_ptr] <= 1'b0;
            r_reg_write     <= 1'b1;
            r_write_reg     <= r_reg_q[r_rd_ptr];
            r_write_data    <= r_data_q[r_rd_ptr];
         end else begin
            r_reg_write     <= 1'b0;
         end
         r_count <= r_count + COUNT_W'(w_push) - COUNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_reg_q[r_wr_ptr]  <= w_acc_reg;
         r_data_q[r_wr_ptr] <= w_acc_data;
      end
   end

   always_comb begin
      w_pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i]) begin
            w_pending[r_reg_q[i]] = 1'b1;
         end
      end
      if (r_reg_write) begin
         w_pending[r_write_reg] = 1'b1;
      end
      w_pending[0] = 1'b0;
   end

   assign regWrite  = r_reg_write;
   assign writeReg  = r_write_reg;
   assign writeData = r_write_data;
   assign pending   = w_pending;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_writeback_queue : directed self-checking bench for writeback_queue
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_writeback_queue;

   logic        clk;
   logic        rst_n;
   logic        hold;
   logic        regWrite;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic [31:0] pending;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   int checks   = 0;
   int failures = 0;

   writeback_queue_if #(.DATA_W(32), .ADDR_W(5)) wb ();

   writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb        (wb),
      .hold      (hold),
      .regWrite  (regWrite),
      .writeReg  (writeReg),
      .writeData (writeData),
      .pending   (pending),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] q[$];
      logic [4:0] popped;
      int sent;
      int got;
      int dut_writes;
      int mcount;
      bit do_push;
      bit do_pop;

      rst_n        = 1'b0;
      hold         = 1'b0;
      wb.mem_valid = 1'b0;
      wb.mem_reg   = '0;
      wb.mem_data  = '0;
      wb.alu_valid = 1'b0;
      wb.alu_reg   = '0;
      wb.alu_data  = '0;

      // Reset state
      step();
      step();
      check("rst_regWrite", regWrite, 0);
      check("rst_writeReg", writeReg, 0);
      check("rst_writeData", writeData, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_pending", pending, 0);
      check("rst_mem_ready", wb.mem_ready, 0);
      check("rst_alu_ready", wb.alu_ready, 0);
      rst_n = 1'b1;
      #1;
      check("rel_mem_ready", wb.mem_ready, 1);
      step();

      // 1: single ALU write, latency and pending
      wb.alu_valid = 1'b1; wb.alu_reg = 5'd8; wb.alu_data = 32'h1234;
      #1;
      check("t1_alu_ready", wb.alu_ready, 1);
      step();
      wb.alu_valid = 1'b0;
      check("t1_count1", count, 1);
      check("t1_pending_q", pending, 32'h100);
      check("t1_regWrite0", regWrite, 0);
      step();
      check("t1_regWrite", regWrite, 1);
      check("t1_writeReg", writeReg, 8);
      check("t1_writeData", writeData, 32'h1234);
      check("t1_pending_out", pending, 32'h100);
      check("t1_count0", count, 0);
      step();
      check("t1_regWrite_off", regWrite, 0);
      check("t1_pending_clr", pending, 0);
      check("t1_writeData_hold", writeData, 32'h1234);

      // 2: mem priority over alu
      wb.mem_valid = 1'b1; wb.mem_reg = 5'd9;  wb.mem_data = 32'hAAAA;
      wb.alu_valid = 1'b1; wb.alu_reg = 5'd10; wb.alu_data = 32'hBBBB;
      #1;
      check("t2_mem_ready", wb.mem_ready, 1);
      check("t2_alu_ready", wb.alu_ready, 0);
      step();
      wb.mem_valid = 1'b0;
      #1;
      check("t2_alu_ready_next", wb.alu_ready, 1);
      step();
      wb.alu_valid = 1'b0;
      check("t2_w1_en", regWrite, 1);
      check("t2_w1_reg", writeReg, 9);
      check("t2_w1_data", writeData, 32'hAAAA);
      step();
      check("t2_w2_en", regWrite, 1);
      check("t2_w2_reg", writeReg, 10);
      check("t2_w2_data", writeData, 32'hBBBB);
      step();
      check("t2_idle", regWrite, 0);

      // 3: fill under hold, stall 5th, drain in order
      hold = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wb.alu_valid = 1'b1;
         wb.alu_reg   = 5'(11 + k);
         wb.alu_data  = 32'h100 + 32'(k);
         step();
      end
      wb.alu_valid = 1'b0;
      wb.mem_valid = 1'b1; wb.mem_reg = 5'd15; wb.mem_data = 32'h5555;
      #1;
      check("t3_full", full, 1);
      check("t3_count4", count, 4);
      check("t3_mem_ready0", wb.mem_ready, 0);
      check("t3_alu_ready0", wb.alu_ready, 0);
      check("t3_regWrite_held", regWrite, 0);
      step();
      check("t3_stall_count", count, 4);
      hold = 1'b0;
      #1;
      check("t3_ready_before_pop", wb.mem_ready, 0);
      step();
      check("t3_a_reg", writeReg, 11);
      check("t3_a_data", writeData, 32'h100);
      check("t3_a_count", count, 3);
      check("t3_a_pending", pending, 32'h7800);
      check("t3_a_mem_ready", wb.mem_ready, 1);
      step();
      wb.mem_valid = 1'b0;
      check("t3_b_reg", writeReg, 12);
      check("t3_b_count", count, 3);
      step();
      check("t3_c_reg", writeReg, 13);
      check("t3_c_en", regWrite, 1);
      step();
      check("t3_d_reg", writeReg, 14);
      step();
      check("t3_e_reg", writeReg, 15);
      check("t3_e_data", writeData, 32'h5555);
      check("t3_e_en", regWrite, 1);
      check("t3_e_empty", empty, 1);
      step();
      check("t3_f_idle", regWrite, 0);

      // 4: $0 write is dropped
      wb.alu_valid = 1'b1; wb.alu_reg = 5'd0; wb.alu_data = 32'hFFFF;
      #1;
      check("t4_alu_ready", wb.alu_ready, 1);
      step();
      wb.alu_valid = 1'b0;
      check("t4_count", count, 0);
      check("t4_pending", pending, 0);
      check("t4_regWrite", regWrite, 0);
      step();
      check("t4_regWrite2", regWrite, 0);

      // 5: continuous mem stream with hold toggling every 3 cycles
      sent = 0; got = 0; dut_writes = 0; mcount = 0;
      for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
         wb.mem_valid = (sent < 10);
         wb.mem_reg   = 5'(sent + 1);
         wb.mem_data  = 32'hC000 + 32'(sent + 1);
         hold         = ((cyc / 3) % 2) == 1;
         #1;
         check("t5_mem_ready", wb.mem_ready, (mcount < 4));
         do_push = wb.mem_valid && (mcount < 4);
         do_pop  = (mcount > 0) && !hold;
         popped  = '0;
         if (do_pop) popped = q.pop_front();
         if (do_push) begin
            q.push_back(5'(sent + 1));
            sent++;
         end
         mcount = q.size();
         step();
         if (regWrite) dut_writes++;
         if (do_pop) begin
            got++;
            check("t5_en", regWrite, 1);
            check("t5_reg", writeReg, popped);
            check("t5_data", writeData, 32'hC000 + 32'(popped));
         end else begin
            check("t5_idle", regWrite, 0);
         end
      end
      wb.mem_valid = 1'b0;
      hold = 1'b0;
      step();
      check("t5_total_writes", dut_writes, 10);
      check("t5_final_count", count, 0);
      check("t5_final_idle", regWrite, 0);

      // 6: reset mid-stream discards queued entries
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wb.alu_valid = 1'b1;
         wb.alu_reg   = 5'(20 + k);
         wb.alu_data  = 32'h2000 + 32'(k);
         step();
      end
      wb.alu_valid = 1'b0;
      check("t6_count3", count, 3);
      hold = 1'b0;
      step();
      check("t6_pre_en", regWrite, 1);
      check("t6_pre_reg", writeReg, 20);
      wb.mem_valid = 1'b1; wb.mem_reg = 5'd5; wb.mem_data = 32'h77;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_regWrite", regWrite, 0);
      check("t6_rst_count", count, 0);
      check("t6_rst_pending", pending, 0);
      check("t6_rst_writeReg", writeReg, 0);
      check("t6_rst_mem_ready", wb.mem_ready, 0);
      step();
      check("t6_rst_hold_count", count, 0);
      check("t6_rst_hold_ready", wb.mem_ready, 0);
      wb.mem_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      check("t6_rel_mem_ready", wb.mem_ready, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         check("t6_no_write", regWrite, 0);
      end
      check("t6_empty", empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
